systolic_operand_feeder: RTL and testbench
==========================================

Name: systolic_operand_feeder

Overview:
- Upstream stage of the PE array: buffers one DIM x DIM operand tile (A columns, B rows) loaded as packed bus words.
- Replays the tile as diagonally skewed per-lane byte streams into the array's left edge (data_A) and top edge (data_B).
- Drives start_operation into the PEs for the full compute window, then flags completion.

Parameters:
- DATA_WIDTH, 8, width of one operand element (matches PE data_A/data_B).
- BUS_WIDTH, 32, width of packed load/feed words; DIM = BUS_WIDTH/DATA_WIDTH (localparam, default 4); BUS_WIDTH must be an exact multiple of DATA_WIDTH.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- load_i  in  1  write one operand vector pair this cycle.
- load_a_i  in  BUS_WIDTH  A vector k; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH] = A[i][k].
- load_b_i  in  BUS_WIDTH  B vector k; lane j = B[k][j].
- go_i  in  1  start feeding a fully loaded tile.
- full_o  out  1  DIM vectors loaded, tile ready.
- busy_o  out  1  FEED in progress.
- done_o  out  1  one-cycle pulse after the last feed cycle.
- start_operation_o  out  1  to PE start_operation_i.
- data_A_o  out  BUS_WIDTH  lane i to PE row i, column 0.
- data_B_o  out  BUS_WIDTH  lane j to PE row 0, column j.

Behaviour:
- Reset (async, any state including mid-FEED): state=IDLE, write pointer wp=0, load count cnt=0, feed counter t=0; all outputs 0. Buffer contents need not be cleared.
- States: IDLE -> FEED -> DONE -> IDLE.
- IDLE load:
  - load_i with cnt<DIM writes buf_a[wp], buf_b[wp], then wp++ and cnt++.
  - load_i with cnt==DIM is ignored; buffer is unchanged.
- IDLE go:
  - full_o = (cnt==DIM), registered.
  - go_i with cnt==DIM goes to FEED and sets t=0.
  - go_i with cnt<DIM is ignored; no error is raised.
  - load_i and go_i in the same cycle: the load is evaluated first against the pre-edge cnt, and go uses the pre-edge cnt. So at cnt==DIM-1 the load is accepted and go is ignored; at cnt==DIM the load is ignored and go is accepted.
- FEED output timing:
  - Lasts T = 3*DIM-2 cycles (t = 0..T-1). All outputs are registered.
  - In the first FEED cycle after the go edge, outputs already show t=0 values.
  - start_operation_o=1 and busy_o=1 throughout FEED.
- FEED lane values: lane i of data_A_o = buf_a[t-i] lane i if 0 <= t-i < DIM, else 0. data_B_o uses the same rule with buf_b.
- FEED cycle budget: 2*DIM-1 cycles carry data; the trailing DIM-1 zero cycles let the last operands reach PE[DIM-1][DIM-1].
- load_i and go_i are ignored during FEED and DONE.
- DONE (1 cycle):
  - done_o=1; start_operation_o=0; data outputs 0; busy_o=0.
  - cnt and wp cleared; full_o=0 on the next cycle.
  - Returns to IDLE.
- Counters: t is $clog2(3*DIM-1) bits wide and must never wrap inside FEED. wp wraps DIM-1 -> 0 but is gated by cnt.
- No arithmetic on data; element values pass through unmodified, unsigned.

Decomposition:
- Shared package holds:
  - feeder state enum (IDLE, FEED, DONE);
  - the DIM derivation (BUS_WIDTH/DATA_WIDTH);
  - FEED length constant (3*DIM-2);
  - lane slice helper (lane index -> bit offset).
- One sub-module, operand_tile_buf: a DIM-entry x BUS_WIDTH register file with write port (wp, data) and a skewed combinational read per lane (t, i -> element or 0). Instantiate it twice, once for A and once for B.
- Top level owns the FSM, counters and output registers.

Test Plan (DIM=4; load vector k with A lane i = 10k+i+1, B lane j = 100+10k+j):
- Reset mid-FEED at t=5 -> all outputs 0 immediately (async); full_o=0; a subsequent go_i without reload is ignored.
- Load 3 vectors then go_i -> ignored: busy_o stays 0, start_operation_o stays 0.
- Load 4 vectors, then go_i:
  - t=0: data_A_o lanes {0,0,0,1}; data_B_o lane0=100.
  - t=3: A lanes (0..3) = 31,22,13,4.
  - t=6: only lane3=34.
  - t=7..9: all zero with start_operation_o=1.
  - Next cycle: done_o=1 for exactly 1 cycle.
- Fifth load_i while full -> ignored; replay still shows vector-3 values (lane0=31 at t=3).
- load_i+go_i together at cnt==3 -> load taken, no FEED. At cnt==4 with load_i+go_i -> FEED starts, buffer unchanged.
- Back-to-back tiles: reload 4 vectors after done_o, go_i -> second FEED identical in timing, new data, with no stale values.

Source files
------------

// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic operand feeder.
// Contents:
//   feeder_state_e      : FSM states (IDLE, FEED, DONE)
//   calc_dim()          : number of lanes carried by one bus word
//   calc_feed_len()     : cycles spent in FEED for a DIM x DIM tile
//   lane_offset()       : bit offset of a lane inside a packed bus word
package systolic_operand_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BUS_WIDTH  = 32;

    // Lanes per bus word; BUS_WIDTH is expected to be a multiple of DATA_WIDTH.
    function automatic int calc_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // 2*DIM-1 cycles carry skewed data, then DIM-1 zero cycles drain the
    // last operands down to the far corner PE.
    function automatic int calc_feed_len(input int dim);
        return (3 * dim) - 2;
    endfunction

    // Bit offset of lane 'lane' in a packed word of 'width'-bit elements.
    function automatic int lane_offset(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_operand_tile_buf.sv
// operand_tile_buf: DIM-entry x BUS_WIDTH register file holding one operand
// tile edge (A columns or B rows), with a diagonally skewed read.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   we_i           : write enable for entry wp_i
//   wp_i           : write pointer (vector index k)
//   wdata_i        : packed vector k, lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   t_i            : feed step used for the skewed read
//   rdata_o        : lane i = entry[t_i - i] lane i when 0 <= t_i-i < DIM, else 0
module operand_tile_buf
    import systolic_operand_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int DIM        = calc_dim(DEF_BUS_WIDTH, DEF_DATA_WIDTH),
    parameter int PTR_W      = (DIM > 1) ? $clog2(DIM) : 1,
    parameter int T_W        = $clog2(3 * DIM - 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 we_i,
    input  logic [PTR_W-1:0]     wp_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    input  logic [T_W-1:0]       t_i,
    output logic [BUS_WIDTH-1:0] rdata_o
);

    logic [BUS_WIDTH-1:0] mem_r [DIM];
    logic [BUS_WIDTH-1:0] rdata_s;

    // Storage: one packed vector per entry, written in load order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < DIM; k++) begin
                mem_r[k] <= '0;
            end
        end else if (we_i) begin
            mem_r[wp_i] <= wdata_i;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Skewed read: lane i lags lane 0 by i steps, so lane i shows entry t-i.
    // At most one k matches per lane, so OR-accumulating selects it.
    always_comb begin
        rdata_s = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) begin
                rdata_s[lane_offset(i, DATA_WIDTH) +: DATA_WIDTH] =
                    rdata_s[lane_offset(i, DATA_WIDTH) +: DATA_WIDTH] |
                    ((t_i == T_W'(k + i)) ? mem_r[k][lane_offset(i, DATA_WIDTH) +: DATA_WIDTH]
                                          : {DATA_WIDTH{1'b0}});
            end
        end
    end

    assign rdata_o = rdata_s;

endmodule

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: buffers one DIM x DIM operand tile and replays it
// as diagonally skewed byte streams into the left (A) and top (B) edges of the
// PE array, holding start_operation high for the whole compute window.
// Ports:
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   load_i             : write one A/B vector pair (accepted while not full, IDLE only)
//   load_a_i, load_b_i : packed A column k / B row k
//   go_i               : start feeding a full tile (IDLE only)
//   full_o             : DIM vectors loaded
//   busy_o             : FEED in progress
//   done_o             : one-cycle pulse after the last feed cycle
//   start_operation_o  : to PE start_operation_i, high throughout FEED
//   data_A_o, data_B_o : skewed lane streams into PE row i / column j
module systolic_operand_feeder
    import systolic_operand_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic [BUS_WIDTH-1:0] load_a_i,
    input  logic [BUS_WIDTH-1:0] load_b_i,
    input  logic                 go_i,
    output logic                 full_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 start_operation_o,
    output logic [BUS_WIDTH-1:0] data_A_o,
    output logic [BUS_WIDTH-1:0] data_B_o
);

    localparam int DIM      = calc_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int FEED_LEN = calc_feed_len(DIM);
    localparam int T_W      = $clog2(3 * DIM - 1);
    localparam int PTR_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CNT_W    = $clog2(DIM + 1);

    localparam logic [T_W-1:0]   T_LAST   = T_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIM);
    localparam logic [PTR_W-1:0] WP_LAST  = PTR_W'(DIM - 1);

    feeder_state_e        state_r, state_nxt_s;
    logic [PTR_W-1:0]     wp_r, wp_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [T_W-1:0]       t_r, t_nxt_s;
    logic                 we_s;
    logic                 busy_nxt_s, done_nxt_s, start_nxt_s, feed_nxt_s;

    logic                 full_r, busy_r, done_r, start_r;
    logic [BUS_WIDTH-1:0] data_a_r, data_b_r;
    logic [BUS_WIDTH-1:0] rd_a_s, rd_b_s;

    // The buffers are read at the next step so the registered outputs
    // already carry the t=0 values in the first FEED cycle.
    operand_tile_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .DIM        (DIM),
        .PTR_W      (PTR_W),
        .T_W        (T_W)
    ) u_buf_a (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (we_s),
        .wp_i    (wp_r),
        .wdata_i (load_a_i),
        .t_i     (t_nxt_s),
        .rdata_o (rd_a_s)
    );

    operand_tile_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .DIM        (DIM),
        .PTR_W      (PTR_W),
        .T_W        (T_W)
    ) u_buf_b (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (we_s),
        .wp_i    (wp_r),
        .wdata_i (load_b_i),
        .t_i     (t_nxt_s),
        .rdata_o (rd_b_s)
    );

    // Next-state, counter updates and next output values.
    always_comb begin
        state_nxt_s = state_r;
        wp_nxt_s    = wp_r;
        cnt_nxt_s   = cnt_r;
        t_nxt_s     = t_r;
        we_s        = 1'b0;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        start_nxt_s = 1'b0;
        feed_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Load and go both look at the pre-edge count.
                if (load_i && (cnt_r < CNT_FULL)) begin
                    we_s      = 1'b1;
                    wp_nxt_s  = (wp_r == WP_LAST) ? {PTR_W{1'b0}} : (wp_r + PTR_W'(1));
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    we_s      = 1'b0;
                end
                if (go_i && (cnt_r == CNT_FULL)) begin
                    state_nxt_s = ST_FEED;
                    t_nxt_s     = {T_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                    start_nxt_s = 1'b1;
                    feed_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (t_r == T_LAST) begin
                    state_nxt_s = ST_DONE;
                    t_nxt_s     = {T_W{1'b0}};
                    done_nxt_s  = 1'b1;
                end else begin
                    t_nxt_s     = t_r + T_W'(1);
                    busy_nxt_s  = 1'b1;
                    start_nxt_s = 1'b1;
                    feed_nxt_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                wp_nxt_s    = {PTR_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                wp_nxt_s    = {PTR_W{1'b0}};
                t_nxt_s     = {T_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            wp_r    <= {PTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            t_r     <= {T_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wp_r    <= wp_nxt_s;
            cnt_r   <= cnt_nxt_s;
            t_r     <= t_nxt_s;
        end
    end

    // Output registers; data lanes are forced to zero outside FEED.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            start_r  <= 1'b0;
            data_a_r <= {BUS_WIDTH{1'b0}};
            data_b_r <= {BUS_WIDTH{1'b0}};
        end else begin
            full_r   <= (cnt_nxt_s == CNT_FULL);
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            start_r  <= start_nxt_s;
            data_a_r <= feed_nxt_s ? rd_a_s : {BUS_WIDTH{1'b0}};
            data_b_r <= feed_nxt_s ? rd_b_s : {BUS_WIDTH{1'b0}};
        end
    end

    assign full_o            = full_r;
    assign busy_o            = busy_r;
    assign done_o            = done_r;
    assign start_operation_o = start_r;
    assign data_A_o          = data_a_r;
    assign data_B_o          = data_b_r;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder (DIM=4).
module tb_systolic_operand_feeder;

    localparam int DW  = 8;
    localparam int BW  = 32;
    localparam int DIM = 4;
    localparam int T   = 3 * DIM - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic          go;
    logic [BW-1:0] la;
    logic [BW-1:0] lb;
    logic          full, busy, done, start;
    logic [BW-1:0] data_a, data_b;

    systolic_operand_feeder #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .load_i            (load),
        .load_a_i          (la),
        .load_b_i          (lb),
        .go_i              (go),
        .full_o            (full),
        .busy_o            (busy),
        .done_o            (done),
        .start_operation_o (start),
        .data_A_o          (data_a),
        .data_B_o          (data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic          start;
        logic          busy;
        logic          done;
        logic          full;
    } exp_t;

    typedef struct {
        int            t;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } spot_t;

    exp_t          sb_q[$];
    spot_t         spots[6];
    logic [BW-1:0] mdl_a[DIM];
    logic [BW-1:0] mdl_b[DIM];
    int            mcnt  = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " data_A"}, data_a, e.a);
        chk({tag, " data_B"}, data_b, e.b);
        chk({tag, " start"}, {31'd0, start}, {31'd0, e.start});
        chk({tag, " busy"},  {31'd0, busy},  {31'd0, e.busy});
        chk({tag, " done"},  {31'd0, done},  {31'd0, e.done});
        chk({tag, " full"},  {31'd0, full},  {31'd0, e.full});
    endtask

    // Vector k of a data set: lane i = base + 10k + i (+ extra).
    function automatic logic [BW-1:0] mk_vec(input int base, input int k);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < DIM; i++) v[i*DW +: DW] = 8'(base + 10 * k + i);
        return v;
    endfunction

    // Reference skew: lane i shows vector t-i when it exists, else zero.
    function automatic logic [BW-1:0] skew(input bit sel_b, input int t);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) begin
                if (t - i == k) r[i*DW +: DW] = sel_b ? mdl_b[k][i*DW +: DW] : mdl_a[k][i*DW +: DW];
            end
        end
        return r;
    endfunction

    function automatic void push_feed();
        exp_t e;
        for (int t = 0; t < T; t++) begin
            e = '{skew(1'b0, t), skew(1'b1, t), 1'b1, 1'b1, 1'b0, 1'b1};
            sb_q.push_back(e);
        end
        e = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        sb_q.push_back(e);
        e = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        sb_q.push_back(e);
    endfunction

    // Drive one load cycle and update the model if the DUT should take it.
    task automatic load_vec(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit with_go);
        load = 1'b1;
        go   = with_go;
        la   = a;
        lb   = b;
        if (mcnt < DIM) begin
            mdl_a[mcnt] = a;
            mdl_b[mcnt] = b;
            mcnt++;
        end
        tick();
        load = 1'b0;
        go   = 1'b0;
    endtask

    task automatic load_set(input int base_a, input int base_b, input int n);
        for (int k = 0; k < n; k++) load_vec(mk_vec(base_a, k), mk_vec(base_b, k), 1'b0);
    endtask

    // Pops expectations one cycle at a time; first sample is t=0.
    task automatic run_feed(input string tag, input bit use_spots);
        exp_t e;
        int   t;
        t = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_all($sformatf("%s t%0d", tag, t), e);
            if (use_spots) begin
                foreach (spots[s]) begin
                    if (spots[s].t == t) begin
                        chk($sformatf("%s spotA t%0d", tag, t), data_a, spots[s].a);
                        chk($sformatf("%s spotB t%0d", tag, t), data_b, spots[s].b);
                    end
                end
            end
            t++;
            if (sb_q.size() > 0) tick();
        end
        mcnt = 0;
    endtask

    task automatic chk_idle(input string tag, input logic exp_full);
        chk({tag, " busy"},  {31'd0, busy},  32'd0);
        chk({tag, " start"}, {31'd0, start}, 32'd0);
        chk({tag, " full"},  {31'd0, full},  {31'd0, exp_full});
    endtask

    initial begin
        spots[0] = '{0, 32'h0000_0001, 32'h0000_0064};
        spots[1] = '{3, {8'd4, 8'd13, 8'd22, 8'd31}, {8'd103, 8'd112, 8'd121, 8'd130}};
        spots[2] = '{6, {8'd34, 24'd0}, {8'd133, 24'd0}};
        spots[3] = '{7, 32'd0, 32'd0};
        spots[4] = '{8, 32'd0, 32'd0};
        spots[5] = '{9, 32'd0, 32'd0};

        rst_n = 1'b1;
        load  = 1'b0;
        go    = 1'b0;
        la    = '0;
        lb    = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk_all("reset", '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        tick();

        // Partial tile: go must be ignored.
        load_set(1, 100, 3);
        chk_idle("three loaded", 1'b0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_idle("go at cnt3", 1'b0);
        tick();
        chk_idle("go at cnt3 +1", 1'b0);

        // Fourth vector fills the tile; a fifth is dropped.
        load_vec(mk_vec(1, 3), mk_vec(100, 3), 1'b0);
        chk_idle("four loaded", 1'b1);
        load_vec(32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b0);
        chk_idle("fifth load", 1'b1);

        // First tile with spot checks.
        push_feed();
        go = 1'b1;
        tick();
        go = 1'b0;
        run_feed("tile1", 1'b1);

        // Simultaneous load+go at cnt==3: load wins, no FEED.
        load_set(41, 161, 3);
        load_vec(mk_vec(41, 3), mk_vec(161, 3), 1'b1);
        chk_idle("load+go cnt3", 1'b1);
        tick();
        chk_idle("load+go cnt3 +1", 1'b1);

        // load+go at cnt==4: FEED starts, buffer keeps the earlier data.
        push_feed();
        load_vec(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        run_feed("tile2", 1'b0);

        // Back-to-back tile with fresh data.
        load_set(81, 201, 4);
        push_feed();
        go = 1'b1;
        tick();
        go = 1'b0;
        run_feed("tile3", 1'b0);

        // Asynchronous reset in the middle of FEED.
        load_set(1, 100, 4);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midfeed t5 start", {31'd0, start}, 32'd1);
        chk("midfeed t5 A", data_a, skew(1'b0, 5));
        #2 rst_n = 1'b0;
        #1;
        chk_all("async reset", '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        rst_n = 1'b1;
        mcnt  = 0;
        chk_idle("after reset", 1'b0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_idle("go after reset", 1'b0);
        tick();
        chk_idle("go after reset +1", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
